// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - mode-0 SPI master with valid/ready request and response channels
module spi_master_ctrl #(
  parameter int DATA_W = 32,
  parameter int DIV    = 2,
  parameter int NSS    = 8,
  localparam int LEN_W = $clog2(DATA_W),
  localparam int SEL_W = $clog2(NSS)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sck,
  output logic [NSS-1:0]    ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W = $clog2(DIV) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, RESP} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rx;
  logic              half;
  logic [LEN_W-1:0]  next_idx;

  // A half-period has elapsed once the divider reaches its last count.
  assign half     = (div_cnt == DIV_W'(DIV - 1));
  // Bits go out MSB-first from position len down to 0.
  assign next_idx = len_q - bit_cnt - LEN_W'(1);

  // Transfer sequencer: owns sck, slave selects, mosi and both handshakes.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      div_cnt   <= '0;
      len_q     <= '0;
      bit_cnt   <= '0;
      wdata_q   <= '0;
      rx        <= '0;
      sck       <= 1'b0;
      ss        <= '1;
      mosi      <= 1'b1;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (req_valid && req_ready) begin
            wdata_q   <= req_wdata;
            len_q     <= req_len;
            bit_cnt   <= '0;
            rx        <= '0;
            // An out-of-range select leaves every line deasserted.
            for (int i = 0; i < NSS; i++) begin
              ss[i] <= (req_sel != SEL_W'(i));
            end
            mosi      <= req_wdata[req_len];
            req_ready <= 1'b0;
            state     <= SETUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP, LOW: begin
          if (half) begin
            div_cnt <= '0;
            sck     <= 1'b1;
            rx      <= {rx[DATA_W-2:0], miso};
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HIGH: begin
          if (half) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            if (bit_cnt == len_q) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + LEN_W'(1);
              mosi    <= wdata_q[next_idx];
              state   <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HOLD: begin
          if (half) begin
            div_cnt   <= '0;
            ss        <= '1;
            mosi      <= 1'b1;
            rsp_rdata <= rx;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        RESP: begin
          // Ready rises together with the return to IDLE so the next request
          // can be taken on the following edge.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl
module tb_spi_master_ctrl;
  localparam int DATA_W = 32;
  localparam int DIV    = 2;
  localparam int NSS    = 6;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_wdata;
  logic [4:0]  req_len;
  logic [2:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        sck;
  logic [5:0]  ss;
  logic        mosi;
  logic        miso = 1'b0;

  spi_master_ctrl #(.DATA_W(DATA_W), .DIV(DIV), .NSS(NSS)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wdata(req_wdata),
    .req_len(req_len), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] mosi_bits;
    int          len;
    logic [5:0]  ss_act;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Slave models: mode 0 loops mosi back one edge late, mode 1 is a bitrev device on ss[0].
  int         mode = 0;
  logic       sck_s = 1'b0;
  logic       mosi_hi = 1'b1;
  logic [7:0] byte_in = 8'h00;
  int         bcnt = 5;

  always @(negedge clock) begin
    if (req_valid && req_ready) begin
      miso = 1'b0;
    end else if (mode == 0) begin
      if (sck) mosi_hi = mosi;
      else if (sck_s) miso = mosi_hi;
    end else begin
      if (sck && !sck_s) begin
        if (ss[0]) bcnt = 0;
        else begin
          if (bcnt < 8) byte_in = {byte_in[6:0], mosi};
          bcnt++;
        end
      end else if (!sck && sck_s && !ss[0] && bcnt >= 9 && bcnt <= 16) begin
        miso = byte_in[bcnt-9];
      end
    end
    sck_s = sck;
  end

  // Monitor: measures each transfer and scores it against the queue when the response is taken.
  int          cyc = 0, lat = 0, rises = 0, highs = 0, hold_bad = 0, ss_bad = 0;
  int          acc_cyc = 0, rsp_cyc = 0;
  logic        waiting = 1'b0, got_valid = 1'b0, sck_m = 1'b0;
  logic [31:0] mosi_seq = '0, held = '0;
  exp_t        e;

  always @(negedge clock) begin
    cyc++;
    if (!resetn) begin
      waiting = 1'b0;
    end else begin
      if (waiting) begin
        if (sck && !sck_m) begin
          rises++;
          mosi_seq = {mosi_seq[30:0], mosi};
        end
        if (sck) begin
          highs++;
          if (q.size() > 0 && ss !== q[0].ss_act) ss_bad++;
        end
        if (!got_valid) begin
          lat++;
          if (rsp_valid) begin
            got_valid = 1'b1;
            held = rsp_rdata;
          end
        end else if (rsp_rdata !== held || req_ready) begin
          hold_bad++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cyc = cyc;
        if (q.size() == 0 || !waiting) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("rdata", rsp_rdata, e.rdata);
          check("mosi_bits", mosi_seq, e.mosi_bits);
          check("sck_rises", 32'(rises), 32'(e.len + 1));
          check("sck_high_clks", 32'(highs), 32'(DIV * (e.len + 1)));
          check("latency", 32'(lat), 32'((2 * (e.len + 1) + 1) * DIV + 1));
          check("ss_during_xfer_bad", 32'(ss_bad), 32'd0);
          check("rsp_hold_bad", 32'(hold_bad), 32'd0);
          check("ss_after", 32'(ss), 32'h3f);
          check("mosi_after", 32'(mosi), 32'd1);
        end
        waiting = 1'b0;
      end
      if (req_valid && req_ready) begin
        waiting = 1'b1; got_valid = 1'b0;
        lat = 0; rises = 0; highs = 0; hold_bad = 0; ss_bad = 0; mosi_seq = '0;
        acc_cyc = cyc;
      end
    end
    sck_m = sck;
  end

  function automatic logic [31:0] len_mask(input int len);
    logic [63:0] m;
    m = (64'd1 << (len + 1)) - 64'd1;
    return m[31:0];
  endfunction

  task automatic send(input logic [31:0] w, input int len, input int sel, input logic [31:0] exp_r);
    exp_t x;
    int   n;
    x.rdata     = exp_r;
    x.mosi_bits = w & len_mask(len);
    x.len       = len;
    x.ss_act    = (sel < NSS) ? ~(6'd1 << sel) : 6'h3f;
    q.push_back(x);
    @(posedge clock); #1;
    req_valid = 1'b1; req_wdata = w; req_len = 5'(len); req_sel = 3'(sel);
    n = 0;
    while (!req_ready && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    if (!req_ready) check("req_accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    if (q.size() > 0) begin
      check("rsp_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int   n, r;
    logic prev, seen;
    resetn = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0;
    req_wdata = '0; req_len = '0; req_sel = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_ss", 32'(ss), 32'h3f);
    check("rst_mosi", 32'(mosi), 32'd1);
    resetn = 1'b1;
    @(posedge clock); #1;
    check("req_ready_after_rst", 32'(req_ready), 32'd1);

    // Loopback, 0x5A: first sample is 0, then wdata bits one edge late.
    send(32'h5a, 7, 0, 32'h2d);
    wait_idle();

    // Bitrev slave: dummy transfer on ss[1] resets it, then the real one on ss[0].
    mode = 1;
    send(32'hf, 3, 1, 32'h0);
    wait_idle();
    send(32'h0001_4a00, 16, 0, 32'ha5);
    wait_idle();
    mode = 0;

    // Single-bit transfer exercises the minimum latency and sck high time.
    send(32'h1, 0, 2, 32'h0);
    wait_idle();

    // Backpressure: response held 10 clocks while a second request waits.
    rsp_ready = 1'b0;
    send(32'hc3, 7, 3, 32'h61);
    n = 0;
    while (!rsp_valid && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    fork
      send(32'h9, 3, 4, 32'h4);
      begin
        repeat (10) @(posedge clock);
        #1;
        rsp_ready = 1'b1;
      end
    join
    check("accept_gap", 32'(acc_cyc - rsp_cyc), 32'd1);
    wait_idle();

    // Reset at the 3rd sck rise of a 16-bit transfer.
    send(32'hbeef, 15, 5, 32'h5f77);
    r = 0; n = 0; prev = sck;
    while (r < 3 && n < 500) begin
      @(posedge clock); #1;
      if (sck && !prev) r++;
      prev = sck;
      n++;
    end
    check("reset_third_rise", 32'(r), 32'd3);
    resetn = 1'b0;
    @(posedge clock); #1;
    check("abort_sck", 32'(sck), 32'd0);
    check("abort_ss", 32'(ss), 32'h3f);
    check("abort_mosi", 32'(mosi), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    if (q.size() > 0) void'(q.pop_front());
    resetn = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clock); #1;
      seen = seen | rsp_valid;
    end
    check("no_rsp_after_abort", 32'(seen), 32'd0);
    send(32'hbeef, 15, 5, 32'h5f77);
    wait_idle();

    // Out-of-range select: no ss line moves, transfer still completes.
    send(32'h3c, 7, 7, 32'h1e);
    wait_idle();

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
